// File: rtl/screen_write_ctrl.sv
// screen_write_ctrl
// Write-side sequencer for the text screen RAM. It prints an 8-bit value as
// three ASCII decimal digits into the value field after the label, and it
// fills a region with a clear character. Both jobs share the one RAM write
// port, and this block arbitrates between them.
//
// Ports
//   clk, rst_n     clock, async active-low reset
//   clear_req      request a region clear (collapsed into a pending flag while busy)
//   value_valid    value_in valid; source holds it until value_ready
//   value_in       unsigned value to print
//   value_ready    combinational accept indication (IDLE, no clear outstanding)
//   busy           state != IDLE
//   done           one-cycle completion pulse (print or clear)
//   ram_we/waddr/wdata  registered screen RAM write port
module screen_write_ctrl #(
    parameter int          ADDR_W     = 12,
    parameter int          FIELD_ADDR = 2485,
    parameter int          CLEAR_BASE = 0,
    parameter int          CLEAR_LEN  = 4096,
    parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_req,
    input  logic              value_valid,
    input  logic [7:0]        value_in,
    output logic              value_ready,
    output logic              busy,
    output logic              done,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [7:0]        ram_wdata
);

    localparam int CNT_W = $clog2(CLEAR_LEN + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, CONVERT, WRITE, DONE} state_t;

    state_t           state, state_nx;
    logic             clear_pending;
    logic [CNT_W-1:0] clr_cnt;    // next clear offset to write
    logic [7:0]       rem;        // remainder after digit subtraction
    logic [1:0]       h;          // hundreds digit (0..2)
    logic [3:0]       t;          // tens digit (0..9)
    logic [1:0]       wr_idx;     // next digit to write in WRITE (1,2), 3 = finished
    logic [7:0]       hund_ch, tens_ch, ones_ch;

    // Leading zeros become spaces; the ones digit is always printed.
    assign hund_ch = (h != 2'd0) ? (8'h30 + {6'd0, h}) : 8'h20;
    assign tens_ch = ((h != 2'd0) || (t != 4'd0)) ? (8'h30 + {4'd0, t}) : 8'h20;
    assign ones_ch = 8'h30 + rem;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        value_ready = (state == IDLE) && !clear_req && !clear_pending;
        case (state)
            IDLE: begin
                if (clear_req || clear_pending) state_nx = CLEAR;
                else if (value_valid)           state_nx = CONVERT;
            end
            CLEAR:   if (clr_cnt == CNT_W'(CLEAR_LEN)) state_nx = DONE;
            CONVERT: if (rem < 8'd10)                  state_nx = WRITE;
            WRITE:   if (wr_idx == 2'd3)               state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Write-port outputs are issued on the same edge that enters or advances
    // the writing state, so the first write appears right as CONVERT ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clear_pending <= 1'b0;
            clr_cnt       <= '0;
            rem           <= 8'd0;
            h             <= 2'd0;
            t             <= 4'd0;
            wr_idx        <= 2'd0;
            done          <= 1'b0;
            ram_we        <= 1'b0;
            ram_waddr     <= '0;
            ram_wdata     <= 8'd0;
        end else begin
            ram_we <= 1'b0;
            done   <= (state == DONE);

            // Requests arriving while busy collapse into one pending clear.
            if (state != IDLE && clear_req)
                clear_pending <= 1'b1;
            else if (state == IDLE && state_nx == CLEAR)
                clear_pending <= 1'b0;

            case (state)
                IDLE: begin
                    if (state_nx == CLEAR) begin
                        ram_we    <= 1'b1;
                        ram_waddr <= ADDR_W'(CLEAR_BASE);
                        ram_wdata <= CLEAR_CHAR;
                        clr_cnt   <= CNT_W'(1);
                    end else if (state_nx == CONVERT) begin
                        rem <= value_in;
                        h   <= 2'd0;
                        t   <= 4'd0;
                    end
                end
                CLEAR: begin
                    if (state_nx == CLEAR) begin
                        ram_we    <= 1'b1;
                        ram_waddr <= ADDR_W'(CLEAR_BASE) + ADDR_W'(clr_cnt);
                        ram_wdata <= CLEAR_CHAR;
                        clr_cnt   <= clr_cnt + CNT_W'(1);
                    end
                end
                CONVERT: begin
                    if (rem >= 8'd100) begin
                        rem <= rem - 8'd100;
                        h   <= h + 2'd1;
                    end else if (rem >= 8'd10) begin
                        rem <= rem - 8'd10;
                        t   <= t + 4'd1;
                    end else begin
                        ram_we    <= 1'b1;
                        ram_waddr <= ADDR_W'(FIELD_ADDR);
                        ram_wdata <= hund_ch;
                        wr_idx    <= 2'd1;
                    end
                end
                WRITE: begin
                    case (wr_idx)
                        2'd1: begin
                            ram_we    <= 1'b1;
                            ram_waddr <= ADDR_W'(FIELD_ADDR + 1);
                            ram_wdata <= tens_ch;
                            wr_idx    <= 2'd2;
                        end
                        2'd2: begin
                            ram_we    <= 1'b1;
                            ram_waddr <= ADDR_W'(FIELD_ADDR + 2);
                            ram_wdata <= ones_ch;
                            wr_idx    <= 2'd3;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
